// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared bus widths, result payload type and constants for the CDB arbiter
package cdb_arbiter_pkg;

    localparam int NICK_W  = 5;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int ROB_NUM = 32;

    localparam logic NOT_JUMP = 1'b0;
    localparam logic SRC_EX   = 1'b0;
    localparam logic SRC_SLB  = 1'b1;

    typedef struct packed {
        logic [NICK_W-1:0] nick;
        logic [DATA_W-1:0] dt;
        logic              ac;
        logic [ADDR_W-1:0] j_pc;
    } cdb_res_t;

    localparam cdb_res_t RES_RST = '{nick: '0, dt: '0, ac: NOT_JUMP, j_pc: '0};

    // Tag 0 is reserved and never names a real ROB entry.
    function automatic logic nick_valid(input logic [NICK_W-1:0] n);
        return n != '0;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: small per-source result FIFO with registered count, flush and freeze
module cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     head_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    assign head_o  = mem_q[rp_q];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == (PTR_W+1)'(DEPTH);

    // Next pointers and count; flush wins, and a push with a pop leaves the count unchanged.
    always_comb begin
        wp_d  = clr_i ? '0 : wp_q + PTR_W'(push_i);
        rp_d  = clr_i ? '0 : rp_q + PTR_W'(pop_i);
        cnt_d = clr_i ? '0 : cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end

    // Pointer and count registers, frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (rdy_i) begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage; contents need no reset because the count guards every read.
    always_ff @(posedge clk) begin
        if (rst && rdy_i && !clr_i && push_i)
            mem_q[wp_q] <= din_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the CDB between EX and SLB result FIFOs (optional same-cycle bypass: CDB_BYPASS_EN)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iROB_clr,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [DATA_W-1:0] iEX_dt,
    input  logic              iEX_ac,
    input  logic [ADDR_W-1:0] iEX_j_pc,
    output logic              oEX_full,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [DATA_W-1:0] iSLB_dt,
    output logic              oSLB_full,
    output logic              oCDB_en,
    output logic              oCDB_src,
    output logic [NICK_W-1:0] oCDB_nick,
    output logic [DATA_W-1:0] oCDB_dt,
    output logic              oCDB_ac,
    output logic [ADDR_W-1:0] oCDB_j_pc
);

    cdb_res_t       ex_live, slb_live, ex_head, slb_head, sel, out_q, out_d;
    logic [PTR_W:0] ex_cnt, slb_cnt;
    logic           ex_full, slb_full, ex_req, slb_req, ex_empty, slb_empty;
    logic           ex_byp, slb_byp, ex_elig, slb_elig, gnt_ex, gnt_slb, gnt_any, upd;
    logic           ex_push, slb_push, ex_pop, slb_pop;
    logic           en_q, en_d, src_q, src_d, last_q, last_d;

    assign ex_live  = '{nick: iEX_nick, dt: iEX_dt, ac: iEX_ac, j_pc: iEX_j_pc};
    assign slb_live = '{nick: iSLB_nick, dt: iSLB_dt, ac: NOT_JUMP, j_pc: '0};
    assign ex_req   = iEX_en && nick_valid(iEX_nick);
    assign slb_req  = iSLB_en && nick_valid(iSLB_nick);
    assign ex_empty  = ex_cnt == '0;
    assign slb_empty = slb_cnt == '0;

`ifdef CDB_BYPASS_EN
    assign ex_byp  = ex_empty && ex_req;
    assign slb_byp = slb_empty && slb_req;
`else
    assign ex_byp  = 1'b0;
    assign slb_byp = 1'b0;
`endif

    // Grant from registered counts (plus live bypass requests); ties go opposite to last_grant.
    always_comb begin
        ex_elig  = !ex_empty || ex_byp;
        slb_elig = !slb_empty || slb_byp;
        gnt_slb  = slb_elig && (!ex_elig || last_q == SRC_EX);
        gnt_ex   = ex_elig && !gnt_slb;
        gnt_any  = gnt_ex || gnt_slb;
        sel      = gnt_slb ? (slb_empty ? slb_live : slb_head) : (ex_empty ? ex_live : ex_head);
        ex_pop   = gnt_ex && !ex_empty;
        slb_pop  = gnt_slb && !slb_empty;
        ex_push  = ex_req && !ex_full && !iROB_clr && !(gnt_ex && ex_empty);
        slb_push = slb_req && !slb_full && !iROB_clr && !(gnt_slb && slb_empty);
    end

    cdb_fifo #(.W($bits(cdb_res_t)), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ex_fifo (
        .clk    (clk),
        .rst    (rst),
        .rdy_i  (rdy),
        .clr_i  (iROB_clr),
        .push_i (ex_push),
        .pop_i  (ex_pop),
        .din_i  (ex_live),
        .head_o (ex_head),
        .count_o(ex_cnt),
        .full_o (ex_full)
    );

    cdb_fifo #(.W($bits(cdb_res_t)), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_slb_fifo (
        .clk    (clk),
        .rst    (rst),
        .rdy_i  (rdy),
        .clr_i  (iROB_clr),
        .push_i (slb_push),
        .pop_i  (slb_pop),
        .din_i  (slb_live),
        .head_o (slb_head),
        .count_o(slb_cnt),
        .full_o (slb_full)
    );

    // Broadcast register next state; payload fields hold when nothing is granted or on flush.
    always_comb begin
        upd    = rdy && !iROB_clr && gnt_any;
        en_d   = rdy ? upd : en_q;
        src_d  = upd ? gnt_slb : src_q;
        out_d  = upd ? sel : out_q;
        last_d = upd ? gnt_slb : last_q;
    end

    // Broadcast and round-robin state; last_grant resets to SLB so EX wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q   <= 1'b0;
            src_q  <= SRC_EX;
            out_q  <= RES_RST;
            last_q <= SRC_SLB;
        end else begin
            en_q   <= en_d;
            src_q  <= src_d;
            out_q  <= out_d;
            last_q <= last_d;
        end
    end

    assign oCDB_en   = en_q;
    assign oCDB_src  = src_q;
    assign oCDB_nick = out_q.nick;
    assign oCDB_dt   = out_q.dt;
    assign oCDB_ac   = out_q.ac;
    assign oCDB_j_pc = out_q.j_pc;
    assign oEX_full  = ex_full;
    assign oSLB_full = slb_full;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed checks of cdb_arbiter against a queue-based reference model
module tb_cdb_arbiter;

    localparam int DEPTH = 4;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic        src;
        logic [4:0]  nick;
        logic [31:0] dt;
        logic        ac;
        logic [31:0] pc;
    } m_t;

    logic        clk = 0, rst = 0, rdy = 1, iROB_clr = 0;
    logic        iEX_en = 0, iEX_ac = 0, iSLB_en = 0;
    logic [4:0]  iEX_nick = 0, iSLB_nick = 0;
    logic [31:0] iEX_dt = 0, iEX_j_pc = 0, iSLB_dt = 0;
    logic        oEX_full, oSLB_full, oCDB_en, oCDB_src, oCDB_ac;
    logic [4:0]  oCDB_nick;
    logic [31:0] oCDB_dt, oCDB_j_pc;
    logic [73:0] obs;

    int total = 0, bad = 0;

    m_t   exq[$], slbq[$];
    m_t   m_out = '0;
    logic m_en = 0;
    int   last = 1;

    cdb_arbiter #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(iROB_clr),
        .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt), .iEX_ac(iEX_ac), .iEX_j_pc(iEX_j_pc),
        .oEX_full(oEX_full),
        .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt), .oSLB_full(oSLB_full),
        .oCDB_en(oCDB_en), .oCDB_src(oCDB_src), .oCDB_nick(oCDB_nick), .oCDB_dt(oCDB_dt),
        .oCDB_ac(oCDB_ac), .oCDB_j_pc(oCDB_j_pc)
    );

    always #5 clk = ~clk;

    assign obs = {oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc, oEX_full, oSLB_full};

    always @(posedge clk)
        if (rst && rdy && !iROB_clr)
            assert (!(iEX_en && oEX_full) && !(iSLB_en && oSLB_full))
            else $error("protocol violation: request while full");

    function automatic logic [73:0] exp_v();
        return {m_en, m_out, exq.size() == DEPTH, slbq.size() == DEPTH};
    endfunction

    task automatic idle_in();
        iEX_en = 0; iSLB_en = 0; iROB_clr = 0; rdy = 1;
        iEX_nick = 0; iSLB_nick = 0; iEX_dt = 0; iSLB_dt = 0; iEX_ac = 0; iEX_j_pc = 0;
    endtask

    task automatic drive_ex(input int nick);
        iEX_en = 1; iEX_nick = 5'(nick); iEX_dt = $urandom; iEX_ac = 1'($urandom); iEX_j_pc = $urandom;
    endtask

    task automatic drive_slb(input int nick);
        iSLB_en = 1; iSLB_nick = 5'(nick); iSLB_dt = $urandom;
    endtask

    // Reference model: one clock edge applied to per-source result queues, then the edge itself.
    task automatic tick();
        m_t el, sl, r;
        bit exr, slr, exe, sle;
        int g;
        el = '{1'b0, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc};
        sl = '{1'b1, iSLB_nick, iSLB_dt, 1'b0, 32'd0};
        if (!rst) begin
            exq.delete(); slbq.delete(); last = 1; m_en = 0; m_out = '0;
        end else if (rdy) begin
            if (iROB_clr) begin
                exq.delete(); slbq.delete(); m_en = 0;
            end else begin
                exr = iEX_en && iEX_nick != 0 && exq.size() < DEPTH;
                slr = iSLB_en && iSLB_nick != 0 && slbq.size() < DEPTH;
                exe = exq.size() > 0;
                sle = slbq.size() > 0;
`ifdef CDB_BYPASS_EN
                exe = exe || exr;
                sle = sle || slr;
`endif
                g = (exe && sle) ? (last == 1 ? 0 : 1) : exe ? 0 : sle ? 1 : -1;
                m_en = g >= 0;
                if (g == 0) begin
                    if (exq.size() > 0) r = exq.pop_front(); else begin r = el; exr = 0; end
                    m_out = r; last = 0;
                end else if (g == 1) begin
                    if (slbq.size() > 0) r = slbq.pop_front(); else begin r = sl; slr = 0; end
                    m_out = r; last = 1;
                end
                if (exr) exq.push_back(el);
                if (slr) slbq.push_back(sl);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_in(); rst = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== 74'd0) begin bad++; $display("FAIL reset: got %h want 0", obs); end
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL reset_model: got %h want %h", obs, exp_v()); end
        end
        rst = 1;
    endtask

    task automatic test_single();
        drive_ex(3); iEX_dt = 32'h12345678; iEX_ac = 1; iEX_j_pc = 32'h100;
        for (int i = 1; i <= 3; i++) begin
            tick(); idle_in();
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL single_model c%0d: got %h want %h", i, obs, exp_v()); end
            total++;
            if (oCDB_en !== (i == LAT)) begin bad++; $display("FAIL single_en c%0d: got %b want %b", i, oCDB_en, i == LAT); end
            if (i == LAT) begin
                total++;
                if ({oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc} !== {1'b0, 5'd3, 32'h12345678, 1'b1, 32'h100}) begin
                    bad++; $display("FAIL single_data: got %b %0d %h %b %h", oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc);
                end
            end
        end
    endtask

    task automatic tie_round(input int a, input int b);
        int got[$];
        drive_ex(5); drive_slb(6);
        for (int i = 0; i < 5; i++) begin
            tick(); idle_in();
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL tie_model c%0d: got %h want %h", i, obs, exp_v()); end
            if (oCDB_en) got.push_back(int'(oCDB_nick));
        end
        total++;
        if (got.size() != 2 || got[0] != a || got[1] != b)
            begin bad++; $display("FAIL tie_order: got %p want %0d,%0d", got, a, b); end
    endtask

    task automatic test_tie();
        idle_in(); rst = 0; tick(); rst = 1;
        tie_round(5, 6);
        drive_ex(7);
        for (int i = 0; i < 3; i++) begin
            tick(); idle_in();
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL tie_mid c%0d: got %h want %h", i, obs, exp_v()); end
        end
        tie_round(6, 5);
    endtask

    task automatic test_fill();
        int slb_sent = 0, ex_sent = 0, ex_seen = 0;
        int slb_got[$];
        bit srcs[$];
        bit saw_full = 0;
        for (int c = 0; c < 34; c++) begin
            idle_in();
            if (c < 14 && exq.size() < DEPTH) begin drive_ex(10 + c); ex_sent++; end
            if (slb_sent < 10 && slbq.size() < DEPTH && !saw_full) begin drive_slb(slb_sent + 1); slb_sent++; end
            tick();
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL fill_model c%0d: got %h want %h", c, obs, exp_v()); end
            if (oSLB_full) saw_full = 1;
            if (oCDB_en) begin
                srcs.push_back(oCDB_src);
                if (oCDB_src) slb_got.push_back(int'(oCDB_nick)); else ex_seen++;
            end
        end
        total++;
        if (!saw_full) begin bad++; $display("FAIL fill_full: got 0 want 1"); end
        total++;
        if (slb_got.size() != slb_sent || ex_seen != ex_sent)
            begin bad++; $display("FAIL fill_lost: got slb=%0d ex=%0d want slb=%0d ex=%0d", slb_got.size(), ex_seen, slb_sent, ex_sent); end
        foreach (slb_got[i]) begin
            total++;
            if (slb_got[i] != i + 1) begin bad++; $display("FAIL fill_order %0d: got %0d want %0d", i, slb_got[i], i + 1); end
        end
        for (int i = 1; i < 8 && i < srcs.size(); i++) begin
            total++;
            if (srcs[i] == srcs[i-1]) begin bad++; $display("FAIL fill_alt %0d: got src %b twice", i, srcs[i]); end
        end
    endtask

    task automatic test_flush();
        bit found = 0;
        for (int c = 0; c < 5; c++) begin
            idle_in(); drive_ex(20 + c); drive_slb(25 + c);
            tick();
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL flush_pre c%0d: got %h want %h", c, obs, exp_v()); end
        end
        idle_in(); drive_slb(30); drive_ex(31); iROB_clr = 1;
        tick(); idle_in();
        total++;
        if (oCDB_en !== 0 || oEX_full !== 0 || oSLB_full !== 0)
            begin bad++; $display("FAIL flush_now: got en=%b exf=%b slbf=%b want 0 0 0", oCDB_en, oEX_full, oSLB_full); end
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (oCDB_en !== 0) begin bad++; $display("FAIL flush_quiet c%0d: got en=%b nick=%0d want en=0", c, oCDB_en, oCDB_nick); end
        end
        drive_ex(9);
        for (int c = 0; c < 4; c++) begin
            tick(); idle_in();
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL flush_post c%0d: got %h want %h", c, obs, exp_v()); end
            if (oCDB_en && oCDB_nick == 9 && oCDB_src == 0) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL flush_new: got no nick 9 want nick 9"); end
    endtask

    task automatic test_edges();
        int got[$];
        int n = 1;
        logic [73:0] prev;
        idle_in(); drive_ex(0); drive_slb(0);
        for (int c = 0; c < 4; c++) begin
            tick(); idle_in();
            total++;
            if (oCDB_en !== 0) begin bad++; $display("FAIL nick0 c%0d: got en=%b want 0", c, oCDB_en); end
        end
        for (int c = 0; c < 16; c++) begin
            idle_in();
            rdy = !(c >= 3 && c < 6);
            if (n <= 8) drive_ex(n);
            prev = obs;
            tick();
            if (rdy && n <= 8) n++;
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL rdy_model c%0d: got %h want %h", c, obs, exp_v()); end
            if (!rdy) begin
                total++;
                if (obs !== prev) begin bad++; $display("FAIL rdy_hold c%0d: got %h want %h", c, obs, prev); end
            end
            if (oCDB_en && rdy) got.push_back(int'(oCDB_nick));
        end
        foreach (got[i]) begin
            total++;
            if (got[i] != i + 1) begin bad++; $display("FAIL rdy_order %0d: got %0d want %0d", i, got[i], i + 1); end
        end
        total++;
        if (got.size() != 8) begin bad++; $display("FAIL rdy_count: got %0d want 8", got.size()); end
        for (int c = 0; c < 3; c++) begin
            idle_in(); drive_ex(11 + c); drive_slb(14 + c);
            tick();
        end
        idle_in(); drive_ex(17); rst = 0;
        tick(); rst = 1; idle_in();
        total++;
        if (obs !== 74'd0) begin bad++; $display("FAIL midreset: got %h want 0", obs); end
        tick();
        total++;
        if (obs !== exp_v()) begin bad++; $display("FAIL midreset_after: got %h want %h", obs, exp_v()); end
    endtask

    task automatic test_wrap();
        int got[$];
        for (int c = 0; c < 26; c++) begin
            idle_in();
            if (c < 20) drive_ex(c + 1);
            tick();
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL wrap_model c%0d: got %h want %h", c, obs, exp_v()); end
            total++;
            if (oEX_full !== 0) begin bad++; $display("FAIL wrap_full c%0d: got 1 want 0", c); end
            if (oCDB_en) got.push_back(int'(oCDB_nick));
        end
        total++;
        if (got.size() != 20) begin bad++; $display("FAIL wrap_count: got %0d want 20", got.size()); end
        foreach (got[i]) begin
            total++;
            if (got[i] != i + 1) begin bad++; $display("FAIL wrap_order %0d: got %0d want %0d", i, got[i], i + 1); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle_in();
            rdy = ($urandom % 8) != 0;
            iROB_clr = ($urandom % 40) == 0;
            if (exq.size() < DEPTH && $urandom % 3 != 0) drive_ex($urandom % 32);
            if (slbq.size() < DEPTH && $urandom % 2 != 0) drive_slb($urandom % 32);
            tick();
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL random c%0d: got %h want %h", c, obs, exp_v()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fill();
        test_flush();
        test_edges();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
